// File: rtl/pipe_stage_latch_if.sv
// Valid/ready stream bundle carrying one pipeline beat: datapath payload plus
// the control fields that are zeroed to form a bubble.
interface pipe_stage_latch_if #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, data, ctrl, input  ready);
   modport slave  (input  valid, data, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_latch.sv
// Parametrised pipeline-stage register with valid/ready handshake, optional
// 2-entry skid buffer, flush, bubble (ctrl=0) output and saturating stall counter.
module pipe_stage_latch #(
   parameter int DATA_W = 128,
   parameter int CTRL_W = 16,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic               CLK,
   input  logic               nRST,
   input  logic               flush,
   pipe_stage_latch_if.slave  up,
   pipe_stage_latch_if.master dn,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt
);
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   state_t            r_state, w_next;
   logic [DATA_W-1:0] r_main_d, r_skid_d;
   logic [CTRL_W-1:0] r_main_c, r_skid_c;
   logic [CNT_W-1:0]  r_cnt;

   logic w_in_ready, w_out_valid, w_acc, w_take;
   logic w_ld_main_in, w_ld_main_skid, w_ld_skid_in;

   // With the skid entry, ready depends only on state so upstream sees a
   // registered signal; without it, ready passes downstream ready through.
   generate
      if (SKID != 0) begin : g_skid
         assign w_in_ready = (r_state != S_TWO);
      end else begin : g_noskid
         assign w_in_ready = (r_state == S_EMPTY) | dn.ready;
      end
   endgenerate

   assign w_out_valid = (r_state != S_EMPTY);
   assign w_acc       = up.valid & w_in_ready;
   assign w_take      = w_out_valid & dn.ready;

   always_comb begin
      w_next         = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid_in   = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_acc) begin
               w_next       = S_ONE;
               w_ld_main_in = 1'b1;
            end
         end
         S_ONE: begin
            if (w_acc && w_take) begin
               w_ld_main_in = 1'b1;
            end else if (w_acc && SKID != 0) begin
               w_next       = S_TWO;
               w_ld_skid_in = 1'b1;
            end else if (w_take) begin
               w_next = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_take) begin
               w_next         = S_ONE;
               w_ld_main_skid = 1'b1;
            end
         end
         default: w_next = S_EMPTY;
      endcase
      // Flush kills held entries and the incoming beat alike.
      if (flush) begin
         w_next         = S_EMPTY;
         w_ld_main_in   = 1'b0;
         w_ld_main_skid = 1'b0;
         w_ld_skid_in   = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= S_EMPTY;
         r_main_d <= '0;
         r_main_c <= '0;
         r_skid_d <= '0;
         r_skid_c <= '0;
      end else begin
         r_state <= w_next;
         if (flush) begin
            r_main_d <= '0;
            r_main_c <= '0;
            r_skid_d <= '0;
            r_skid_c <= '0;
         end else begin
            if (w_ld_main_in) begin
               r_main_d <= up.data;
               r_main_c <= up.ctrl;
            end else if (w_ld_main_skid) begin
               r_main_d <= r_skid_d;
               r_main_c <= r_skid_c;
            end
            if (w_ld_skid_in) begin
               r_skid_d <= up.data;
               r_skid_c <= up.ctrl;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_cnt <= '0;
      end else if (w_out_valid && !dn.ready && r_cnt != {CNT_W{1'b1}}) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign up.ready  = w_in_ready;
   assign dn.valid  = w_out_valid;
   assign dn.data   = r_main_d;
   assign dn.ctrl   = w_out_valid ? r_main_c : '0;
   assign occupancy = r_state;
   assign stall_cnt = r_cnt;
endmodule

// File: tb/tb_pipe_stage_latch.sv
// Drives three stage variants (skid/16-bit cnt, no-skid, skid/4-bit cnt) with
// one stimulus stream and checks each against a queue-based reference model.
module tb_pipe_stage_latch;
   localparam int DW = 32;
   localparam int CW = 8;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;

   always #5 CLK = ~CLK;

   pipe_stage_latch_if #(.DATA_W(DW), .CTRL_W(CW)) up0 ();
   pipe_stage_latch_if #(.DATA_W(DW), .CTRL_W(CW)) dn0 ();
   pipe_stage_latch_if #(.DATA_W(DW), .CTRL_W(CW)) up1 ();
   pipe_stage_latch_if #(.DATA_W(DW), .CTRL_W(CW)) dn1 ();
   pipe_stage_latch_if #(.DATA_W(DW), .CTRL_W(CW)) up2 ();
   pipe_stage_latch_if #(.DATA_W(DW), .CTRL_W(CW)) dn2 ();

   assign up0.valid = in_valid; assign up0.data = in_data; assign up0.ctrl = in_ctrl; assign dn0.ready = out_ready;
   assign up1.valid = in_valid; assign up1.data = in_data; assign up1.ctrl = in_ctrl; assign dn1.ready = out_ready;
   assign up2.valid = in_valid; assign up2.data = in_data; assign up2.ctrl = in_ctrl; assign dn2.ready = out_ready;

   logic [1:0]  occ0, occ1, occ2;
   logic [15:0] sc0, sc1;
   logic [3:0]  sc2;

   pipe_stage_latch #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u0 (
      .CLK(CLK), .nRST(nRST), .flush(flush), .up(up0), .dn(dn0), .occupancy(occ0), .stall_cnt(sc0));
   pipe_stage_latch #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u1 (
      .CLK(CLK), .nRST(nRST), .flush(flush), .up(up1), .dn(dn1), .occupancy(occ1), .stall_cnt(sc1));
   pipe_stage_latch #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u2 (
      .CLK(CLK), .nRST(nRST), .flush(flush), .up(up2), .dn(dn2), .occupancy(occ2), .stall_cnt(sc2));

   logic [59:0] obs [3];
   assign obs[0] = {dn0.valid, up0.ready, occ0, dn0.ctrl, dn0.data, sc0};
   assign obs[1] = {dn1.valid, up1.ready, occ1, dn1.ctrl, dn1.data, sc1};
   assign obs[2] = {dn2.valid, up2.ready, occ2, dn2.ctrl, dn2.data, 12'd0, sc2};

   // Reference model: each stage is a FIFO of at most 2 (or 1) beats.
   logic [CW+DW-1:0] mb [3][2];
   int               mn [3];
   int               mcnt [3];
   logic [DW-1:0]    msh [3];
   int ncmp = 0;
   int nfail = 0;

   function automatic bit m_skid(int k);
      return k != 1;
   endfunction

   function automatic int m_max(int k);
      return (k == 2) ? 15 : 65535;
   endfunction

   function automatic logic m_ir(int k);
      return m_skid(k) ? (mn[k] < 2) : (mn[k] == 0 || out_ready);
   endfunction

   function automatic logic [59:0] m_exp(int k);
      logic v;
      v = mn[k] > 0;
      return {v, m_ir(k), 2'(mn[k]), v ? mb[k][0][CW+DW-1:DW] : 8'h00, msh[k], 16'(mcnt[k])};
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 3; k++) begin
         mn[k] = 0; mcnt[k] = 0; msh[k] = '0;
      end
   endtask

   task automatic m_step();
      logic v, acc, take;
      if (!nRST) return;
      for (int k = 0; k < 3; k++) begin
         v    = mn[k] > 0;
         acc  = in_valid & m_ir(k);
         take = v & out_ready;
         if (v && !out_ready && mcnt[k] < m_max(k)) mcnt[k]++;
         if (flush) begin
            mn[k] = 0; msh[k] = '0;
         end else begin
            if (take) begin mb[k][0] = mb[k][1]; mn[k]--; end
            if (acc)  begin mb[k][mn[k]] = {in_ctrl, in_data}; mn[k]++; end
            if (mn[k] > 0) msh[k] = mb[k][0][DW-1:0];
         end
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      m_step();
      #2;
   endtask

   task automatic idle_in();
      in_valid = 1'b0; in_data = 'x; in_ctrl = 'x;
   endtask

   task automatic test_reset();
      nRST = 1'b0; m_reset(); idle_in();
      #1;
      for (int k = 0; k < 3; k++) begin
         ncmp++;
         if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL reset dut%0d got %h want %h", k, obs[k], m_exp(k)); end
      end
      repeat (2) @(posedge CLK);
      #2 nRST = 1'b1;
   endtask

   task automatic test_streaming();
      flush = 1'b0; out_ready = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         if (i <= 8) begin in_valid = 1'b1; in_data = DW'(i); in_ctrl = CW'(i); end
         else idle_in();
         #1;
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL stream dut%0d got %h want %h", k, obs[k], m_exp(k)); end
         end
         if (i >= 2 && i <= 9) begin
            ncmp++;
            if (dn0.valid !== 1'b1 || dn0.data !== DW'(i - 1)) begin
               nfail++; $display("FAIL stream_order got v=%b d=%h want v=1 d=%h", dn0.valid, dn0.data, i - 1);
            end
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] beats [3];
      logic [DW-1:0] got [$];
      int idx, base;
      logic acc0;
      beats[0] = 32'hA; beats[1] = 32'hB; beats[2] = 32'hC;
      idx = 0; base = mcnt[0]; out_ready = 1'b0;
      for (int c = 0; c < 14; c++) begin
         if (c == 6) begin
            ncmp++;
            if (occ0 !== 2'd2 || up0.ready !== 1'b0) begin
               nfail++; $display("FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occ0, up0.ready);
            end
            ncmp++;
            if (sc0 !== 16'(base + 5)) begin nfail++; $display("FAIL bp_stall got %0d want %0d", sc0, base + 5); end
            out_ready = 1'b1;
         end
         if (idx < 3) begin in_valid = 1'b1; in_data = beats[idx]; in_ctrl = 8'h5A; end
         else idle_in();
         #1;
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL bp dut%0d got %h want %h", k, obs[k], m_exp(k)); end
         end
         if (dn0.valid && out_ready) got.push_back(dn0.data);
         acc0 = in_valid & m_ir(0);
         tick();
         if (acc0) idx++;
      end
      ncmp++;
      if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
         nfail++; $display("FAIL bp_order got %0d beats want A,B,C", got.size());
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 32'h11 + DW'(i); in_ctrl = 8'hC3; #1; tick();
      end
      ncmp++;
      if (occ0 !== 2'd2) begin nfail++; $display("FAIL flush_fill got occ=%0d want 2", occ0); end
      flush = 1'b1; in_valid = 1'b1; in_data = 32'hD; in_ctrl = 8'hFF;
      #1; tick();
      flush = 1'b0; idle_in(); #1;
      ncmp++;
      if (occ0 !== 2'd0 || dn0.ctrl !== 8'h00 || dn0.data !== 32'h0) begin
         nfail++; $display("FAIL flush_empty got occ=%0d ctrl=%h data=%h want 0 0 0", occ0, dn0.ctrl, dn0.data);
      end
      for (int k = 0; k < 3; k++) begin
         ncmp++;
         if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL flush dut%0d got %h want %h", k, obs[k], m_exp(k)); end
      end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick(); #1;
         ncmp++;
         if (dn0.valid !== 1'b0) begin nfail++; $display("FAIL flush_nobeat got valid=%b data=%h want 0", dn0.valid, dn0.data); end
      end
   endtask

   task automatic test_skid0();
      logic [DW-1:0] sent [$];
      logic [DW-1:0] got [$];
      logic [DW-1:0] nxt;
      logic acc1;
      bit ok;
      nxt = 32'h100;
      for (int c = 0; c < 16; c++) begin
         out_ready = (c >= 12) ? 1'b1 : ((c % 3) != 1);
         if (c < 12) begin in_valid = 1'b1; in_data = nxt; in_ctrl = 8'h81; end
         else idle_in();
         #1;
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL skid0 dut%0d got %h want %h", k, obs[k], m_exp(k)); end
         end
         if (occ1 == 2'd1) begin
            ncmp++;
            if (up1.ready !== out_ready) begin nfail++; $display("FAIL skid0_ready got %b want %b", up1.ready, out_ready); end
         end
         if (dn1.valid && out_ready) got.push_back(dn1.data);
         acc1 = in_valid & m_ir(1);
         if (acc1) sent.push_back(nxt);
         tick();
         if (acc1) nxt++;
      end
      ok = (got.size() == sent.size()) && (sent.size() > 4);
      for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) ok = 0;
      ncmp++;
      if (!ok) begin nfail++; $display("FAIL skid0_seq got %0d beats want %0d in order", got.size(), sent.size()); end
   endtask

   task automatic test_saturation();
      #1 nRST = 1'b0; m_reset(); #1 nRST = 1'b1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5A5A; in_ctrl = 8'h01;
      #1; tick();
      idle_in();
      for (int j = 1; j <= 20; j++) begin
         #1;
         ncmp++;
         if (sc2 !== 4'((j - 1) > 15 ? 15 : (j - 1))) begin
            nfail++; $display("FAIL sat_step%0d got %0d want %0d", j, sc2, (j - 1) > 15 ? 15 : (j - 1));
         end
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL sat dut%0d got %h want %h", k, obs[k], m_exp(k)); end
         end
         tick();
      end
      #1;
      ncmp++;
      if (sc2 !== 4'd15 || sc0 !== 16'd20) begin nfail++; $display("FAIL sat_final got %0d/%0d want 15/20", sc2, sc0); end
   endtask

   task automatic test_reset_mid();
      flush = 1'b1; #1; tick(); flush = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 32'h77 + DW'(i); in_ctrl = 8'h3C; #1; tick();
      end
      ncmp++;
      if (occ0 !== 2'd2) begin nfail++; $display("FAIL rstmid_fill got occ=%0d want 2", occ0); end
      nRST = 1'b0; m_reset(); #1;
      ncmp++;
      if (dn0.valid !== 1'b0 || occ0 !== 2'd0 || sc0 !== 16'd0 || up0.ready !== 1'b1) begin
         nfail++; $display("FAIL rstmid got v=%b occ=%0d cnt=%0d rdy=%b want 0 0 0 1", dn0.valid, occ0, sc0, up0.ready);
      end
      for (int k = 0; k < 3; k++) begin
         ncmp++;
         if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL rstmid dut%0d got %h want %h", k, obs[k], m_exp(k)); end
      end
      tick(); nRST = 1'b1; idle_in(); out_ready = 1'b1;
      #1; tick(); #1;
      ncmp++;
      if (dn0.valid !== 1'b0) begin nfail++; $display("FAIL rstmid_nobeat got valid=%b want 0", dn0.valid); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         if (in_valid) begin in_data = $urandom; in_ctrl = 8'($urandom); end
         else begin in_data = 'x; in_ctrl = 'x; end
         #1;
         for (int k = 0; k < 3; k++) begin
            ncmp++;
            if (obs[k] !== m_exp(k)) begin nfail++; $display("FAIL rand%0d dut%0d got %h want %h", c, k, obs[k], m_exp(k)); end
         end
         tick();
      end
      flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_skid0();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
